ldpc_ber_sched_ctrl: RTL and testbench

Parametrised transaction scheduler and accounting block for the LDPC BER tester datapath. It issues CTRL beats to the encoder/channel/decoder chain, limited by a configurable number of in-flight blocks. It runs either continuously or for a fixed block count, then drains. It counts finished and failed blocks from the decoder status stream and raises done once the pipeline is empty.

---
 rtl/ldpc_ber_sched_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ldpc_ber_sched_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_ber_sched_ctrl.sv
// ldpc_ber_sched_ctrl: CTRL-beat scheduler and block accounting for the LDPC BER tester.
// It issues CTRL beats while the in-flight credit allows, runs continuously or for a fixed
// block count, drains, and counts finished/failed blocks from the decoder status stream.
// Optional feature macro: LDPC_SCHED_CYCLES_EN adds a cycle_count output (busy cycles per run).
module ldpc_ber_sched_ctrl #(
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned INFLIGHT_W = 16,
    parameter int unsigned STATUS_W   = 32,
    parameter int unsigned FAIL_BIT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      target_blocks,
    input  logic [INFLIGHT_W-1:0] max_inflight,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    input  logic                  status_valid,
    output logic                  status_ready,
    input  logic [STATUS_W-1:0]   status_data,
    input  logic                  dout_finish,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      issued_blocks,
    output logic [CNT_W-1:0]      finished_blocks,
    output logic [CNT_W-1:0]      failed_blocks,
    output logic [INFLIGHT_W-1:0] in_flight,
`ifdef LDPC_SCHED_CYCLES_EN
    output logic [CNT_W-1:0]      cycle_count,
`endif
    output logic                  underflow
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      target_q, target_d;
    logic [INFLIGHT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      finished_q, finished_d;
    logic [CNT_W-1:0]      failed_q, failed_d;
    logic [INFLIGHT_W-1:0] in_flight_q, in_flight_d;
    logic                  underflow_q, underflow_d;
    logic                  ctrl_valid_q, ctrl_valid_d;
    logic                  status_ready_q;
    logic                  hs;
    logic                  st_hs;
    logic                  start_ok;
    logic                  issue_ok;
`ifdef LDPC_SCHED_CYCLES_EN
    logic [CNT_W-1:0]      cycle_q, cycle_d;
`endif

    assign hs       = ctrl_valid_q & ctrl_ready;
    assign st_hs    = status_valid & status_ready_q;
    assign start_ok = start & ((state_q == StIdle) | (state_q == StDone));

    // Next-state, counter and issue logic
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        max_d       = max_q;
        issued_d    = issued_q + CNT_W'(hs);
        finished_d  = finished_q + CNT_W'(st_hs);
        failed_d    = failed_q + CNT_W'(st_hs & status_data[FAIL_BIT]);
        in_flight_d = in_flight_q;
        underflow_d = underflow_q;
`ifdef LDPC_SCHED_CYCLES_EN
        cycle_d     = cycle_q + CNT_W'(busy);
`endif

        // hs together with dout_finish leaves the count unchanged
        if (hs && !dout_finish) begin
            in_flight_d = in_flight_q + INFLIGHT_W'(1);
        end else if (!hs && dout_finish) begin
            if (in_flight_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                in_flight_d = in_flight_q - INFLIGHT_W'(1);
            end
        end

        // A new run discards everything counted this cycle
        if (start_ok) begin
            target_d    = target_blocks;
            max_d       = (max_inflight == '0) ? INFLIGHT_W'(1) : max_inflight;
            issued_d    = '0;
            finished_d  = '0;
            failed_d    = '0;
            in_flight_d = '0;
            underflow_d = 1'b0;
`ifdef LDPC_SCHED_CYCLES_EN
            cycle_d     = '0;
`endif
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) state_d = StRun;
            end
            StRun: begin
                if (stop || ((target_q != '0) && (issued_d == target_q))) state_d = StDrain;
            end
            StDrain: begin
                if (!ctrl_valid_q && (in_flight_q == '0)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        issue_ok = (state_d == StRun) && (in_flight_d < max_d) &&
                   ((target_d == '0) || (issued_d < target_d));
        // A pending beat is never withdrawn
        ctrl_valid_d = (ctrl_valid_q & ~ctrl_ready) | issue_ok;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            target_q       <= '0;
            max_q          <= INFLIGHT_W'(1);
            issued_q       <= '0;
            finished_q     <= '0;
            failed_q       <= '0;
            in_flight_q    <= '0;
            underflow_q    <= 1'b0;
            ctrl_valid_q   <= 1'b0;
            status_ready_q <= 1'b0;
`ifdef LDPC_SCHED_CYCLES_EN
            cycle_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            max_q          <= max_d;
            issued_q       <= issued_d;
            finished_q     <= finished_d;
            failed_q       <= failed_d;
            in_flight_q    <= in_flight_d;
            underflow_q    <= underflow_d;
            ctrl_valid_q   <= ctrl_valid_d;
            status_ready_q <= 1'b1;
`ifdef LDPC_SCHED_CYCLES_EN
            cycle_q        <= cycle_d;
`endif
        end
    end

    assign ctrl_valid      = ctrl_valid_q;
    assign status_ready    = status_ready_q;
    assign busy            = (state_q == StRun) | (state_q == StDrain);
    assign done            = (state_q == StDone);
    assign issued_blocks   = issued_q;
    assign finished_blocks = finished_q;
    assign failed_blocks   = failed_q;
    assign in_flight       = in_flight_q;
    assign underflow       = underflow_q;
`ifdef LDPC_SCHED_CYCLES_EN
    assign cycle_count     = cycle_q;
`endif

endmodule

// File: tb/tb_ldpc_ber_sched_ctrl.sv
// Self-checking bench for ldpc_ber_sched_ctrl.
module tb_ldpc_ber_sched_ctrl;

    localparam int unsigned CNT_W      = 64;
    localparam int unsigned INFLIGHT_W = 16;
    localparam int unsigned STATUS_W   = 32;
    localparam int unsigned FAIL_BIT   = 0;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic                  stop;
    logic [CNT_W-1:0]      target_blocks;
    logic [INFLIGHT_W-1:0] max_inflight;
    logic                  ctrl_valid;
    logic                  ctrl_ready;
    logic                  status_valid;
    logic                  status_ready;
    logic [STATUS_W-1:0]   status_data;
    logic                  dout_finish;
    logic                  busy;
    logic                  done;
    logic [CNT_W-1:0]      issued_blocks;
    logic [CNT_W-1:0]      finished_blocks;
    logic [CNT_W-1:0]      failed_blocks;
    logic [INFLIGHT_W-1:0] in_flight;
    logic                  underflow;
`ifdef LDPC_SCHED_CYCLES_EN
    logic [CNT_W-1:0]      cycle_count;
`endif

    int vectors;
    int miscompares;

    ldpc_ber_sched_ctrl #(
        .CNT_W      (CNT_W),
        .INFLIGHT_W (INFLIGHT_W),
        .STATUS_W   (STATUS_W),
        .FAIL_BIT   (FAIL_BIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .stop            (stop),
        .target_blocks   (target_blocks),
        .max_inflight    (max_inflight),
        .ctrl_valid      (ctrl_valid),
        .ctrl_ready      (ctrl_ready),
        .status_valid    (status_valid),
        .status_ready    (status_ready),
        .status_data     (status_data),
        .dout_finish     (dout_finish),
        .busy            (busy),
        .done            (done),
        .issued_blocks   (issued_blocks),
        .finished_blocks (finished_blocks),
        .failed_blocks   (failed_blocks),
        .in_flight       (in_flight),
`ifdef LDPC_SCHED_CYCLES_EN
        .cycle_count     (cycle_count),
`endif
        .underflow       (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 50) begin
            step();
            k++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done got %b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; stop = 0; target_blocks = '0; max_inflight = '0;
        ctrl_ready = 0; status_valid = 0; status_data = '0; dout_finish = 0;
        step(); step();
        vectors++;
        if ({ctrl_valid, status_ready, busy, done, underflow} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000",
                     {ctrl_valid, status_ready, busy, done, underflow});
        end
        vectors++;
        if ((issued_blocks | finished_blocks | failed_blocks) !== '0 || in_flight !== '0) begin
            miscompares++;
            $display("FAIL reset_counters got %0d/%0d/%0d/%0d want 0", issued_blocks,
                     finished_blocks, failed_blocks, in_flight);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (status_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got ready=%b busy=%b want 1 0", status_ready, busy);
        end
    endtask

    // target=4, limit 2, each dout_finish 5 cycles after its handshake
    task automatic test_credit_limit();
        int cyc, model, peak;
        int fin_q[$];
        int exp_issued[$];
        logic h, df;
        target_blocks = 4; max_inflight = 2; ctrl_ready = 1;
        start = 1; step(); start = 0;
        vectors++;
        if (ctrl_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_first_valid got %b want 1", ctrl_valid);
        end
        for (int i = 1; i <= 4; i++) exp_issued.push_back(i);
        cyc = 0; model = 0; peak = 0;
        while (!done && cyc < 200) begin
            h  = ctrl_valid & ctrl_ready;
            df = (fin_q.size() > 0) && (fin_q[0] == cyc);
            if (df) void'(fin_q.pop_front());
            dout_finish = df;
            step();
            dout_finish = 0;
            if (h) begin
                fin_q.push_back(cyc + 5);
                model++;
                vectors++;
                if (exp_issued.size() == 0) begin
                    miscompares++;
                    $display("FAIL credit_extra_hs got issued=%0d want none", issued_blocks);
                end else if (issued_blocks !== CNT_W'(exp_issued.pop_front())) begin
                    miscompares++;
                    $display("FAIL credit_issued got %0d want next in sequence", issued_blocks);
                end
            end
            if (df) model--;
            vectors++;
            if (in_flight !== INFLIGHT_W'(model)) begin
                miscompares++;
                $display("FAIL credit_in_flight got %0d want %0d", in_flight, model);
            end
            if (int'(in_flight) > peak) peak = int'(in_flight);
            cyc++;
        end
        vectors++;
        if (done !== 1'b1 || peak != 2) begin
            miscompares++;
            $display("FAIL credit_end got done=%b peak=%0d want 1 2", done, peak);
        end
        vectors++;
        if (issued_blocks !== 4 || in_flight !== 0 || exp_issued.size() != 0) begin
            miscompares++;
            $display("FAIL credit_final got issued=%0d in_flight=%0d want 4 0",
                     issued_blocks, in_flight);
        end
    endtask

    // Continuous mode stalls at the limit with no dout_finish, then drains after stop
    task automatic test_back_to_back();
        int n;
        logic h;
        target_blocks = 0; max_inflight = 8; ctrl_ready = 1;
        start = 1; step(); start = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            h = ctrl_valid & ctrl_ready;
            step();
            if (h) n++;
        end
        vectors++;
        if (n != 8 || ctrl_valid !== 1'b0 || in_flight !== 8) begin
            miscompares++;
            $display("FAIL b2b_limit got hs=%0d valid=%b in_flight=%0d want 8 0 8",
                     n, ctrl_valid, in_flight);
        end
        stop = 1; step(); stop = 0;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain got busy=%b done=%b want 1 0", busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            dout_finish = 1; step(); dout_finish = 0;
        end
        wait_done("b2b");
        vectors++;
        if (in_flight !== 0 || issued_blocks !== 8) begin
            miscompares++;
            $display("FAIL b2b_final got in_flight=%0d issued=%0d want 0 8",
                     in_flight, issued_blocks);
        end
    endtask

    // A beat pending at stop is held, completes and is counted
    task automatic test_stop_pending();
        ctrl_ready = 0; target_blocks = 0; max_inflight = 4;
        start = 1; step(); start = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (ctrl_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stop_hold_run got %b want 1", ctrl_valid);
            end
            step();
        end
        stop = 1; step(); stop = 0;
        step();
        vectors++;
        if (ctrl_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_hold_drain got valid=%b busy=%b want 1 1", ctrl_valid, busy);
        end
        ctrl_ready = 1; step(); ctrl_ready = 0;
        vectors++;
        if (ctrl_valid !== 1'b0 || issued_blocks !== 1 || in_flight !== 1) begin
            miscompares++;
            $display("FAIL stop_beat got valid=%b issued=%0d in_flight=%0d want 0 1 1",
                     ctrl_valid, issued_blocks, in_flight);
        end
        dout_finish = 1; step(); dout_finish = 0;
        wait_done("stop");
    endtask

    // Ten status beats, failure flag on beats 3 and 7; scoreboarded per beat
    task automatic test_status_count();
        int exp_fin[$];
        int exp_fail[$];
        int fin_m, fail_m, ef, efl;
        logic [STATUS_W-1:0] w;
        fin_m = 0; fail_m = 0;
        for (int beat = 1; beat <= 10; beat++) begin
            w = $urandom;
            w[FAIL_BIT] = (beat == 3 || beat == 7);
            status_valid = 1; status_data = w;
            fin_m++;
            if (w[FAIL_BIT]) fail_m++;
            exp_fin.push_back(fin_m);
            exp_fail.push_back(fail_m);
            step();
            status_valid = 0;
            status_data[FAIL_BIT] = 1'b1;  // flagged but not valid: must not count
            ef  = exp_fin.pop_front();
            efl = exp_fail.pop_front();
            vectors++;
            if (finished_blocks !== CNT_W'(ef) || failed_blocks !== CNT_W'(efl)) begin
                miscompares++;
                $display("FAIL status_beat%0d got %0d/%0d want %0d/%0d", beat,
                         finished_blocks, failed_blocks, ef, efl);
            end
            if (beat % 2 == 0) step();
        end
        step();
        vectors++;
        if (finished_blocks !== 10 || failed_blocks !== 2 || status_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL status_final got %0d/%0d ready=%b want 10/2 1",
                     finished_blocks, failed_blocks, status_ready);
        end
    endtask

    // Underflow is sticky until start; simultaneous hs+dout_finish holds in_flight
    task automatic test_underflow_and_simul();
        dout_finish = 1; step(); dout_finish = 0;
        step();
        vectors++;
        if (in_flight !== 0 || underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uflow_set got in_flight=%0d underflow=%b want 0 1",
                     in_flight, underflow);
        end
        ctrl_ready = 0; target_blocks = 0; max_inflight = 8;
        start = 1; step(); start = 0;
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uflow_clear got %b want 0", underflow);
        end
        ctrl_ready = 1;
        step(); step(); step();
        vectors++;
        if (in_flight !== 3 || ctrl_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_pre got in_flight=%0d valid=%b want 3 1", in_flight, ctrl_valid);
        end
        dout_finish = 1; step(); dout_finish = 0; ctrl_ready = 0;
        vectors++;
        if (in_flight !== 3 || issued_blocks !== 4) begin
            miscompares++;
            $display("FAIL simul_hold got in_flight=%0d issued=%0d want 3 4",
                     in_flight, issued_blocks);
        end
        stop = 1; step(); stop = 0;
        ctrl_ready = 1; step(); ctrl_ready = 0;
        for (int i = 0; i < 4; i++) begin
            dout_finish = 1; step(); dout_finish = 0;
        end
        wait_done("simul");
        vectors++;
        if (issued_blocks !== 5 || in_flight !== 0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_final got issued=%0d in_flight=%0d uflow=%b want 5 0 0",
                     issued_blocks, in_flight, underflow);
        end
    endtask

    // max_inflight=0 acts as a limit of 1
    task automatic test_zero_limit();
        int cyc, busy_cyc;
        int fin_q[$];
        logic h, df;
        target_blocks = 3; max_inflight = 0; ctrl_ready = 1;
        start = 1; step(); start = 0;
        busy_cyc = busy ? 1 : 0;
        cyc = 0;
        while (!done && cyc < 200) begin
            h  = ctrl_valid & ctrl_ready;
            df = (fin_q.size() > 0) && (fin_q[0] == cyc);
            if (df) void'(fin_q.pop_front());
            dout_finish = df;
            step();
            dout_finish = 0;
            if (h) fin_q.push_back(cyc + 2);
            if (busy) busy_cyc++;
            vectors++;
            if (in_flight > 1) begin
                miscompares++;
                $display("FAIL zero_limit_in_flight got %0d want <=1", in_flight);
            end
            cyc++;
        end
        vectors++;
        if (done !== 1'b1 || issued_blocks !== 3 || in_flight !== 0) begin
            miscompares++;
            $display("FAIL zero_limit_final got done=%b issued=%0d in_flight=%0d want 1 3 0",
                     done, issued_blocks, in_flight);
        end
`ifdef LDPC_SCHED_CYCLES_EN
        step();
        vectors++;
        if (cycle_count !== CNT_W'(busy_cyc)) begin
            miscompares++;
            $display("FAIL cycle_count got %0d want %0d", cycle_count, busy_cyc);
        end
`endif
    endtask

    // Reset in the middle of a run drops ctrl_valid and clears everything
    task automatic test_reset_midrun();
        ctrl_ready = 0; target_blocks = 0; max_inflight = 4;
        start = 1; step(); start = 0;
        ctrl_ready = 1; step(); ctrl_ready = 0;
        reset = 1; step(); reset = 0;
        vectors++;
        if (ctrl_valid !== 1'b0 || busy !== 1'b0 || in_flight !== 0 || issued_blocks !== 0) begin
            miscompares++;
            $display("FAIL midrun_reset got valid=%b busy=%b in_flight=%0d issued=%0d want 0",
                     ctrl_valid, busy, in_flight, issued_blocks);
        end
        step();
        vectors++;
        if (status_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_after got ready=%b busy=%b done=%b want 1 0 0",
                     status_ready, busy, done);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_credit_limit();
        test_back_to_back();
        test_stop_pending();
        test_status_count();
        test_underflow_and_simul();
        test_zero_limit();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
